// File: rtl/alu_issue.sv
// Issue stage between a ready/valid request port and a registered ALU.
// Optional build macro ALU_ISSUE_OP_CHECK_EN rejects unsupported ops and mod-by-zero without issuing them.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [3:0]  alu_operation,
  output logic [15:0] alu_reg_a,
  output logic [15:0] alu_reg_b,
  input  logic [15:0] alu_c_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_ccr,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    CAPT = 2'b10,
    RESP = 2'b11
  } state_t;

  state_t      state_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_data_r;
  logic        rsp_err_r;
  logic [3:0]  op_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic        reject_s;

`ifdef ALU_ISSUE_OP_CHECK_EN
  // Ops outside 0000-0101 and 1010 are unsupported; mod (1010) by zero is also refused.
  function automatic logic op_rejected(input logic [3:0] op, input logic [15:0] b);
    logic unsupported;
    unsupported = (op > 4'b0101) && (op != 4'b1010);
    return unsupported || ((op == 4'b1010) && (b == 16'h0000));
  endfunction

  assign reject_s = op_rejected(req_op, req_b);
`else
  assign reject_s = 1'b0;
`endif

  // Issue FSM: owns the ALU drive registers and the held response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 16'h0000;
      rsp_err_r   <= 1'b0;
      op_r        <= 4'b0000;
      a_r         <= 16'h0000;
      b_r         <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && reject_s) begin
            state_r     <= RESP;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= 16'h0000;
            rsp_err_r   <= 1'b1;
          end else if (req_valid) begin
            state_r     <= WAIT;
            req_ready_r <= 1'b0;
            op_r        <= req_op;
            a_r         <= req_a;
            b_r         <= req_b;
          end
        end
        WAIT: state_r <= CAPT;
        CAPT: begin
          state_r     <= RESP;
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= alu_c_out;
          rsp_err_r   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_err       = rsp_err_r;
  assign alu_operation = op_r;
  assign alu_reg_a     = a_r;
  assign alu_reg_b     = b_r;
  // Flags come from the captured result, not from the ALU.
  assign rsp_ccr       = {rsp_data_r[15], (rsp_data_r == 16'h0000), 2'b00};

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  upstream request present.
REQ-004 req_ready  output  1  block can accept a request this cycle.
REQ-005 req_op  input  4  ALU operation code, same encoding as the ALU.
REQ-006 req_a, req_b  input  16 each  operands.
REQ-007 alu_operation  output  4  operation code driven to the ALU.
REQ-008 alu_reg_a, alu_reg_b  output  16 each  operands driven to the ALU.
REQ-009 alu_c_out  input  16  registered ALU result; valid one clk after operands are presented.
REQ-010 rsp_valid  output  1  response held for downstream.
REQ-011 rsp_ready  input  1  downstream accepts response.
REQ-012 rsp_data  output  16  captured result.
REQ-013 rsp_ccr  output  4  flags computed locally from rsp_data: bit3 N (rsp_data[15]), bit2 Z (rsp_data==0), bits1:0 zero.
REQ-014 rsp_err  output  1  request rejected, not issued to the ALU.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, CAPT, RESP.
REQ-016 IDLE: req_ready=1; on req_valid, latch req_op/req_a/req_b into the ALU drive registers and go to WAIT.
REQ-017 req_ready SHALL be 1 only in IDLE; no request is accepted in any other state.
REQ-018 WAIT: hold ALU drive registers (ALU samples them at this edge); next state CAPT.
REQ-019 CAPT: latch alu_c_out into rsp_data, clear rsp_err; next state RESP.
REQ-020 RESP: rsp_valid=1; rsp_data/rsp_ccr/rsp_err stable; on rsp_ready go to IDLE; otherwise stay.
REQ-021 Latency SHALL be fixed: acceptance at edge T0, rsp_valid high from T3 (three cycles), for issued requests.
REQ-022 ALU drive registers SHALL hold their last values outside WAIT; only the IDLE acceptance edge changes them.
REQ-023 rsp_ccr SHALL be combinationally derived from rsp_data, never taken from the ALU.
REQ-024 Supported ops: 0000-0101 and 1010; all others are unsupported.
REQ-025 Back-to-back: rsp_ready in RESP returns to IDLE; next acceptance is possible one cycle later (minimum 4-cycle issue interval).
REQ-026 rsp_valid SHALL be 0 in IDLE, WAIT and CAPT.

Reset
REQ-027 reset SHALL force IDLE; rsp_valid=0, rsp_data=0, rsp_err=0, alu_operation=0000, alu_reg_a=0, alu_reg_b=0, req_ready=1 after the reset edge.
REQ-028 reset mid-operation (WAIT, CAPT, RESP) SHALL discard the in-flight request with no response produced.
REQ-029 reset SHALL dominate req_valid and rsp_ready on the same edge.

Configuration
REQ-030 Macro ALU_ISSUE_OP_CHECK_EN, when defined: an unsupported op, or op 1010 with req_b==0, SHALL be accepted in IDLE, not loaded into the ALU drive registers, and go directly to RESP with rsp_data=0, rsp_err=1 (rsp_valid high from T1).
REQ-031 Without ALU_ISSUE_OP_CHECK_EN: every request SHALL follow IDLE-WAIT-CAPT-RESP, and rsp_err SHALL be constant 0.

Verification
REQ-032 and 0x00F0 & 0x0FF0, rsp_ready=1 -> rsp_valid at T3, rsp_data=0x00F0, rsp_ccr=0000, rsp_err=0.
REQ-033 xor 0x8000 ^ 0x0000 with rsp_ready held low 5 cycles -> rsp_data=0x8000, rsp_ccr=1000, held stable 5 cycles; req_ready=0 throughout.
REQ-034 nop_a 0x0000 -> rsp_ccr=0100; second request presented during RESP is not accepted until after the IDLE return.
REQ-035 With ALU_ISSUE_OP_CHECK_EN: mod 7 % 0 -> rsp_valid at T1, rsp_err=1, rsp_data=0, alu_operation unchanged; op 0110 likewise.
REQ-036 reset asserted in CAPT -> next cycle IDLE, rsp_valid=0, all outputs at REQ-027 values, no response for the discarded request.
